// File: rtl/test_monitor.sv
// Simulation test monitor: watches core stores and retires, decides PASS/FAIL/TIMEOUT/HANG.
// All outputs come straight from registers; terminal states hold until reset.
module test_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned TIMEOUT     = 5000,
  parameter int unsigned LOOP_LIMIT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  output logic        done,
  output logic        pass,
  output logic [2:0]  status,
  output logic [30:0] fail_num,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4,
    StHang    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        done_d, pass_d;
  logic [30:0] fail_num_d;
  logic [31:0] cycle_cnt_d, retire_cnt_d;
  logic [31:0] prev_pc_q, prev_pc_d;
  logic [31:0] rep_q, rep_d;
  logic        tohost_hit, same_pc, hang_hit, timeout_hit;

  always_comb begin
    state_d      = state_q;
    fail_num_d   = fail_num;
    cycle_cnt_d  = cycle_cnt;
    retire_cnt_d = retire_cnt;
    prev_pc_d    = prev_pc_q;
    rep_d        = rep_q;
    tohost_hit   = 1'b0;
    same_pc      = 1'b0;
    hang_hit     = 1'b0;
    timeout_hit  = 1'b0;

    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt + 32'd1;
        if (ret_valid && retire_cnt != 32'hFFFF_FFFF) retire_cnt_d = retire_cnt + 32'd1;

        same_pc = ret_valid && (ret_pc == prev_pc_q);
        if (same_pc) begin
          if (rep_q != 32'hFFFF_FFFF) rep_d = rep_q + 32'd1;
        end else if (ret_valid) begin
          rep_d     = 32'd0;
          prev_pc_d = ret_pc;
        end

        // rep counts repeats after the first retire, so the run length is rep + 1
        hang_hit    = same_pc && ((rep_d + 32'd1) == 32'(LOOP_LIMIT));
        timeout_hit = (cycle_cnt_d == 32'(TIMEOUT));
        tohost_hit  = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];

        if (tohost_hit) begin
          if (st_data == 32'd1) begin
            state_d = StPass;
          end else begin
            state_d    = StFail;
            fail_num_d = st_data[31:1];
          end
        end else if (hang_hit) begin
          state_d = StHang;
        end else if (timeout_hit) begin
          state_d = StTimeout;
        end
      end
      default: ;
    endcase

    done_d = (state_d == StPass) || (state_d == StFail) ||
             (state_d == StTimeout) || (state_d == StHang);
    pass_d = (state_d == StPass);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_num   <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      prev_pc_q  <= 32'hFFFF_FFFF;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      done       <= done_d;
      pass       <= pass_d;
      fail_num   <= fail_num_d;
      cycle_cnt  <= cycle_cnt_d;
      retire_cnt <= retire_cnt_d;
      prev_pc_q  <= prev_pc_d;
      rep_q      <= rep_d;
    end
  end

  assign status = state_q;

endmodule

// File: tb/tb_test_monitor.sv
// Scoreboard bench for test_monitor: a run-level reference model predicts each terminal
// outcome, and a monitor compares it whenever done rises.
module tb_test_monitor;

  localparam logic [31:0] TOHOST     = 32'h0000_1000;
  localparam int          TIMEOUT    = 5000;
  localparam int          LOOP_LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0, ret_valid = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0, ret_pc = '0;
  logic        done, pass;
  logic [2:0]  status;
  logic [30:0] fail_num;
  logic [31:0] cycle_cnt, retire_cnt;

  test_monitor #(
    .TOHOST_ADDR(TOHOST),
    .TIMEOUT    (TIMEOUT),
    .LOOP_LIMIT (LOOP_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ret_valid (ret_valid),
    .ret_pc    (ret_pc),
    .done      (done),
    .pass      (pass),
    .status    (status),
    .fail_num  (fail_num),
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [30:0] fn;
    logic [31:0] cc;
    logic [31:0] rc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic done_prev = 1'b0;

  // Reference model: status (0 idle, 1 run, 2..5 terminal), counts, current same-PC run length
  int          m_st = 0;
  logic [31:0] m_cc, m_rc, m_last;
  logic [30:0] m_fn;
  int          m_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got status %0d, expected no terminal event", status);
      end else begin
        e = q.pop_front();
        chk("term_status", 32'(status), 32'(e.st));
        chk("term_pass", 32'(pass), 32'(e.st == 3'd2));
        chk("term_fail_num", 32'(fail_num), 32'(e.fn));
        chk("term_cycle_cnt", cycle_cnt, e.cc);
        chk("term_retire_cnt", retire_cnt, e.rc);
      end
    end
    done_prev = done;
  end

  // Drive one cycle of inputs, advance the model, then step past the next rising edge.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic rv, input logic [31:0] rpc);
    st_valid = sv; st_addr = sa; st_data = sd; ret_valid = rv; ret_pc = rpc;
    if (m_st == 1) begin
      m_cc++;
      if (rv) begin
        m_rc++;
        if (rpc == m_last) m_len++;
        else begin
          m_last = rpc;
          m_len  = 1;
        end
      end
      if (sv && sa == TOHOST && sd[0]) begin
        if (sd == 32'd1) m_st = 2;
        else begin
          m_st = 3;
          m_fn = sd[31:1];
        end
      end else if (rv && m_len == LOOP_LIMIT) begin
        m_st = 5;
      end else if (m_cc == TIMEOUT) begin
        m_st = 4;
      end
      if (m_st != 1) q.push_back('{st: 3'(m_st), fn: m_fn, cc: m_cc, rc: m_rc});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h8000_0000 + ($urandom_range(0, 7) << 2);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    st_valid = 1'b0; ret_valid = 1'b0;
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_fail_num", 32'(fail_num), 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
    m_st = 0; m_cc = 0; m_rc = 0; m_fn = 0; m_last = 32'hFFFF_FFFF; m_len = 0;
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_status", 32'(status), 32'd0);
    @(posedge clk);
    #1;
    m_st = 1;
    chk("run_status", 32'(status), 32'd1);
    chk("run_cycle_cnt", cycle_cnt, 32'd0);
  endtask

  // After a terminal event: keep poking inputs (including a passing store) and expect a freeze.
  task automatic finish_scn(input string name);
    step(1'b1, TOHOST, 32'd1, 1'b1, 32'h8000_0044);
    for (int i = 0; i < 3; i++) step(1'b1, TOHOST, $urandom, 1'b1, rand_pc());
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_missing_done: got done=%0b, expected terminal status %0d",
               name, done, q[0].st);
      q.delete();
    end
    chk({name, "_frozen_status"}, 32'(status), 32'(m_st));
    chk({name, "_frozen_cycle_cnt"}, cycle_cnt, m_cc);
    chk({name, "_frozen_retire_cnt"}, retire_cnt, m_rc);
    chk({name, "_frozen_done"}, 32'(done), 32'(m_st >= 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;

    // PASS at RUN cycle 100
    do_reset();
    for (int k = 0; k < 100; k++) step(1'b0, 32'd0, 32'd0, 1'($urandom % 2), rand_pc());
    step(1'b1, TOHOST, 32'd1, 1'b0, 32'd0);
    chk("pass_cycle_cnt", cycle_cnt, 32'd101);
    finish_scn("pass100");

    // FAIL with test number 3
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b0, 32'd0, 32'd0, 1'($urandom % 2), rand_pc());
    step(1'b1, TOHOST, 32'd7, 1'b1, rand_pc());
    chk("fail_num_3", 32'(fail_num), 32'd3);
    finish_scn("fail7");

    // Store to a neighbouring address, then idle until timeout
    do_reset();
    step(1'b1, TOHOST + 32'd4, 32'd1, 1'b0, 32'd0);
    for (int k = 0; k < TIMEOUT + 100 && m_st == 1; k++) step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("timeout_status", 32'(status), 32'd4);
    chk("timeout_cycle_cnt", cycle_cnt, 32'd5000);
    finish_scn("timeout");

    // Hang: 16 retires at one PC after a different PC
    do_reset();
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0040);
    for (int k = 0; k < 16; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0044);
    chk("hang_status", 32'(status), 32'd5);
    finish_scn("hang");

    // Same stimulus, tohost PASS in the 16th retire cycle wins over HANG
    do_reset();
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0040);
    for (int k = 0; k < 15; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0044);
    step(1'b1, TOHOST, 32'd1, 1'b1, 32'h8000_0044);
    chk("hang_vs_pass_status", 32'(status), 32'd2);
    finish_scn("hang_pass");

    // Even tohost data is ignored
    do_reset();
    step(1'b1, TOHOST, 32'd2, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'd0, 32'd0, 1'b1, rand_pc());
    chk("even_ignored_status", 32'(status), 32'd1);
    step(1'b1, TOHOST, 32'd1, 1'b0, 32'd0);
    finish_scn("even");

    // Asynchronous reset mid-run at cycle_cnt 42
    do_reset();
    for (int k = 0; k < 42; k++) step(1'b0, 32'd0, 32'd0, 1'($urandom % 2), rand_pc());
    chk("pre_async_cycle_cnt", cycle_cnt, 32'd42);
    #2;
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 32'd0, 1'b1, rand_pc());
    chk("restart_cycle_cnt", cycle_cnt, 32'd3);

    // Randomized runs
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 0; k < TIMEOUT + 100 && m_st == 1; k++) begin
        logic        sv;
        logic [31:0] sa, sd;
        sv = ($urandom_range(0, 299) == 0);
        sa = ($urandom % 2) ? TOHOST : TOHOST + 32'd4;
        sd = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
        step(sv, sa, sd, 1'($urandom % 2), rand_pc());
      end
      finish_scn("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
